// File: rtl/approx_mac_pkg.sv
// approx_mac_pkg: shared widths, pipeline stage records and sizing helper for approx_conv_mac.
package approx_mac_pkg;

  localparam int OP_W     = 8;
  localparam int PROD_W   = 16;
  // Product columns below this weight are combined with OR instead of being added.
  localparam int LOW_COLS = 4;

  typedef struct packed {
    logic            valid;
    logic            last;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [PROD_W-1:0] p;
  } s2_t;

  function automatic int min_acc_w(input int klen);
    return PROD_W + $clog2(klen);
  endfunction

endpackage

// File: rtl/approx_8x8.sv
// approx_8x8: unsigned 8x8 approximate multiplier; the low partial-product columns are
// OR-merged (no carries), the remaining columns are summed exactly.
module approx_8x8
  import approx_mac_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] p_o
);

  logic [PROD_W-1:0] hi_sum;
  logic [PROD_W-1:0] lo_or;

  // NOTE: every variable written in a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hi_sum = '0;
    lo_or  = '0;
    for (int i = 0; i < OP_W; i++) begin
      for (int j = 0; j < OP_W; j++) begin
        if (i + j < LOW_COLS) begin
          lo_or = lo_or | (PROD_W'(a_i[i] & b_i[j]) << (i + j));
        end else begin
          hi_sum = hi_sum + (PROD_W'(a_i[i] & b_i[j]) << (i + j));
        end
      end
    end
  end

  // hi_sum has no weight below LOW_COLS, so the OR is an exact concatenation.
  assign p_o = hi_sum | lo_or;

endmodule

// File: rtl/approx_conv_mac.sv
// approx_conv_mac: 3-stage approximate MAC (S1 operands, S2 product, S3 window accumulate).
// Build macro MAC_SAT_EN: saturating accumulator and per-window out_sat flag.
module approx_conv_mac
  import approx_mac_pkg::*;
#(
  parameter int KLEN  = 9,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat
);

  localparam int               IDX_W    = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KLEN - 1);

  if (KLEN < 1 || KLEN > 1024) begin : g_klen_range
    $error("approx_conv_mac: KLEN must be within 1..1024");
  end
  if (ACC_W < PROD_W) begin : g_acc_min
    $error("approx_conv_mac: ACC_W must be at least PROD_W");
  end
  if (ACC_W < min_acc_w(KLEN)) begin : g_acc_narrow
    $info("approx_conv_mac: ACC_W below PROD_W+clog2(KLEN), window sums can overflow");
  end

  logic             ready_en_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;

  logic              advance;
  logic              accept;
  logic              last_in;
  logic              s3_step;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  sum_sel;

  // The whole pipeline freezes while a finished sum waits for the consumer.
  assign advance = !out_valid_q || out_ready;
  assign in_ready = ready_en_q && advance && !flush;
  assign accept   = in_valid && in_ready;
  assign last_in  = (idx_q == IDX_LAST);
  assign s3_step  = !flush && advance && s2_q.valid;

  approx_8x8 u_mult (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .p_o (prod)
  );

`ifdef MAC_SAT_EN
  logic [ACC_W:0] sum_full;
  logic           win_sat;
  logic           sat_q;
  logic           out_sat_q;

  assign sum_full = {1'b0, acc_q} + (ACC_W + 1)'(s2_q.p);
  assign sum_sel  = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
  assign win_sat  = sat_q | sum_full[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q     <= 1'b0;
      out_sat_q <= 1'b0;
    end else if (flush) begin
      sat_q <= 1'b0;
    end else if (s3_step) begin
      sat_q <= win_sat && !s2_q.last;
      if (s2_q.last) begin
        out_sat_q <= win_sat;
      end
    end
  end

  assign out_sat = out_sat_q;
`else
  assign sum_sel = acc_q + ACC_W'(s2_q.p);
  assign out_sat = 1'b0;
`endif

  always_comb begin
    idx_d       = idx_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      // The finished result register survives a flush; only the partial window is dropped.
      idx_d      = '0;
      s1_d.valid = 1'b0;
      s2_d.valid = 1'b0;
      acc_d      = '0;
    end else if (advance) begin
      if (accept) begin
        idx_d = last_in ? '0 : idx_q + IDX_W'(1);
      end
      s1_d.valid = accept;
      s1_d.last  = last_in;
      s1_d.a     = in_a;
      s1_d.b     = in_b;
      s2_d.valid = s1_q.valid;
      s2_d.last  = s1_q.last;
      s2_d.p     = prod;
    end

    if (s3_step) begin
      if (s2_q.last) begin
        out_sum_d   = sum_sel;
        out_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = sum_sel;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q  <= 1'b0;
      idx_q       <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      ready_en_q  <= 1'b1;
      idx_q       <= idx_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_approx_conv_mac.sv
// tb_approx_conv_mac: random and directed stimulus for two approx_conv_mac instances
// (KLEN=4/ACC_W=16 driven directly, KLEN=9/ACC_W=20 fed the same accepted pairs).
module tb_approx_conv_mac;

  localparam int KLEN0 = 4;
  localparam int ACCW0 = 16;
  localparam int KLEN1 = 9;
  localparam int ACCW1 = 20;
`ifdef MAC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACCW0-1:0] out_sum;
  logic             out_sat;

  logic             in_valid9;
  logic             in_ready9;
  logic             out_valid9;
  logic             out_ready9;
  logic [ACCW1-1:0] out_sum9;
  logic             out_sat9;

  always #5 clk = ~clk;

  assign in_valid9  = in_valid && in_ready;
  assign out_ready9 = 1'b1;

  approx_conv_mac #(.KLEN(KLEN0), .ACC_W(ACCW0)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat)
  );

  approx_conv_mac #(.KLEN(KLEN1), .ACC_W(ACCW1)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid9), .in_ready(in_ready9), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid9), .out_ready(out_ready9), .out_sum(out_sum9), .out_sat(out_sat9)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Golden multiplier: exact product, with the four lowest columns replaced by the OR of
  // their partial-product bits.
  function automatic int approx_ref(input int a, input int b);
    int r;
    int lo;
    r  = a * b;
    lo = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4 - i; j++) begin
        if (a[i] && b[j]) begin
          r  = r - (1 << (i + j));
          lo = lo | (1 << (i + j));
        end
      end
    end
    return r + lo;
  endfunction

  typedef struct {
    longint sum;
    bit     sat;
  } res_t;

  res_t   q0[$];
  res_t   q1[$];
  int     win_cnt[2];
  longint win_sum[2];
  res_t   r0, r1;
  int     out_cnt0 = 0;
  logic [31:0] last_sum0 = '0;

  function automatic res_t close_window(input longint s, input int w);
    res_t   r;
    longint max_v;
    max_v = (64'd1 << w) - 1;
    if (SAT_EN && s > max_v) begin
      r.sum = max_v;
      r.sat = 1'b1;
    end else begin
      r.sum = s & max_v;
      r.sat = 1'b0;
    end
    return r;
  endfunction

  function automatic void model_accept(input int k, input int a, input int b);
    win_cnt[k] = win_cnt[k] + 1;
    win_sum[k] = win_sum[k] + longint'(approx_ref(a, b));
    if (k == 0 && win_cnt[0] == KLEN0) begin
      q0.push_back(close_window(win_sum[0], ACCW0));
      win_cnt[0] = 0;
      win_sum[0] = 0;
    end
    if (k == 1 && win_cnt[1] == KLEN1) begin
      q1.push_back(close_window(win_sum[1], ACCW1));
      win_cnt[1] = 0;
      win_sum[1] = 0;
    end
  endfunction

  function automatic void model_clear_windows();
    for (int k = 0; k < 2; k++) begin
      win_cnt[k] = 0;
      win_sum[k] = 0;
    end
  endfunction

  // Monitor: at each falling edge, decide what the next rising edge transfers.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q0.size() == 0) begin
          check("out0_spurious", 32'd1, 32'd0);
        end else begin
          r0 = q0.pop_front();
          check("out0_sum", 32'(out_sum), 32'(r0.sum));
          check("out0_sat", 32'(out_sat), 32'(r0.sat));
          last_sum0 = 32'(out_sum);
          out_cnt0++;
        end
      end
      if (out_valid9) begin
        if (q1.size() == 0) begin
          check("out1_spurious", 32'd1, 32'd0);
        end else begin
          r1 = q1.pop_front();
          check("out1_sum", 32'(out_sum9), 32'(r1.sum));
          check("out1_sat", 32'(out_sat9), 32'(r1.sat));
        end
      end
      if (flush) begin
        model_clear_windows();
      end else begin
        if (in_valid && in_ready) model_accept(0, int'(in_a), int'(in_b));
        if (in_valid9 && in_ready9) model_accept(1, int'(in_a), int'(in_b));
      end
    end
  end

  int ready_gaps = 0;

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int waits;
    waits    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    if (waits > 0) ready_gaps++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    model_clear_windows();
    #1;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_sum"}, 32'(out_sum), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 60) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
  endtask

  bit          phase_done;
  logic [31:0] held;
  int          base_cnt;
  int          sat_exp;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    model_clear_windows();

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Zero-activation window, then a full-scale window with latency and overflow checks.
    for (int i = 0; i < KLEN0; i++) send(8'd0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < KLEN0; i++) send(8'd255, 8'd255);
    check("lat_edge_n", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge_n1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge_n2", 32'(out_valid), 32'd1);
    sat_exp = SAT_EN ? 32'hFFFF : ((KLEN0 * approx_ref(255, 255)) & 32'hFFFF);
    check("full_scale_sum", 32'(out_sum), 32'(sat_exp));
    check("full_scale_sat", 32'(out_sat), 32'(SAT_EN));
    idle(3);

    // Continuous stream at full rate.
    ready_gaps = 0;
    base_cnt   = out_cnt0;
    for (int i = 0; i < 12 * KLEN0; i++) send(rand_op(), rand_op());
    idle(3);
    check("stream_ready_gaps", 32'(ready_gaps), 32'd0);
    check("stream_outputs", 32'(out_cnt0 - base_cnt), 32'd12);

    // Consumer stall after the first result.
    fork
      begin
        for (int i = 0; i < 2 * KLEN0; i++) send(rand_op(), rand_op());
      end
      begin
        int w;
        out_ready = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        check("stall_seen", 32'(out_valid), 32'd1);
        held = 32'(out_sum);
        repeat (10) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_hold", 32'(out_sum), held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(6);

    // Random traffic with random back-pressure.
    phase_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 4) != 0) send(rand_op(), rand_op());
          else idle(1);
        end
        phase_done = 1'b1;
      end
      begin
        while (!phase_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(6);

    // Flush drops a partial window; a pair offered during flush is refused.
    send(rand_op(), rand_op());
    send(rand_op(), rand_op());
    idle(3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_a     = 8'd9;
    in_b     = 8'd9;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < KLEN0; i++) send(8'd1, 8'd1);
    idle(4);
    check("flush_sum", last_sum0, 32'(KLEN0 * approx_ref(1, 1)));
    idle(6);

    // Reset mid-window.
    send(rand_op(), rand_op());
    send(rand_op(), rand_op());
    pulse_reset("rst_mid_window");

    // Reset while a result is stalled.
    out_ready = 1'b0;
    for (int i = 0; i < KLEN0; i++) send(rand_op(), rand_op());
    idle(3);
    check("pre_rst_stall_valid", 32'(out_valid), 32'd1);
    pulse_reset("rst_mid_stall");
    out_ready = 1'b1;

    for (int i = 0; i < 4 * KLEN1; i++) send(rand_op(), rand_op());
    idle(4);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
